// File: rtl/dmem_ctrl.sv
// Data-memory slave on the DAD/DDT/MREQ bus.
// Fixed wait states, byte-lane steering and fault detection.
module dmem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  output logic        ACKD_n,
  output logic        bus_err
);

  localparam int IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0] WLOAD =
    4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [IW-1:0] idx_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic        fault_q;
  logic [31:0] wdata_q;
  logic [31:0] rword_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [IW-1:0] idx_d;
  logic [IW-1:0] rd_idx;
  logic          range_bad;
  logic          align_bad;
  logic          fault_d;
  logic          going_ack;
  logic [3:0]    be;
  logic [31:0]   wsh;
  logic [31:0]   rsh;
  logic [31:0]   rdata;

  assign off   = DAD - BASE_ADDR;
  assign idx_d = IW'(off >> 2);

  assign range_bad = (DAD < BASE_ADDR) ||
                     ({1'b0, DAD} >= LIMIT);
  assign align_bad = (SIZE == 2'b11) ||
                     (SIZE == 2'b01 && DAD[0]) ||
                     (SIZE == 2'b00 && DAD[1:0] != 2'b00);
  assign fault_d   = range_bad | align_bad;

  // The array word is captured on whichever edge enters ACK.
  assign going_ack =
    (state == IDLE && MREQ && WAIT_CYCLES == 0) ||
    (state == WAIT && MREQ && cnt == 4'd0);
  assign rd_idx = (state == IDLE) ? idx_d : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      wdata_q <= 32'd0;
      rword_q <= 32'd0;
    end else begin
      if (going_ack)
        rword_q <= mem[rd_idx];
      unique case (state)
        IDLE: begin
          if (MREQ) begin
            idx_q   <= idx_d;
            lane_q  <= DAD[1:0];
            size_q  <= SIZE;
            wr_q    <= WRITE;
            fault_q <= fault_d;
            wdata_q <= DDT;
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
            end else begin
              cnt   <= WLOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!MREQ) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      2'b00:   be = 4'b1111;
      2'b01:   be = 4'b0011 << lane_q;
      2'b10:   be = 4'b0001 << lane_q;
      default: be = 4'b0000;
    endcase
  end

  assign wsh = wdata_q << {lane_q, 3'b000};

  always_ff @(posedge clk) begin
    if (state == ACK && wr_q && !fault_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[idx_q][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

  assign rsh = rword_q >> {lane_q, 3'b000};

  always_comb begin
    rdata = 32'd0;
    unique case (size_q)
      2'b00:   rdata = rsh;
      2'b01:   rdata = {16'd0, rsh[15:0]};
      2'b10:   rdata = {24'd0, rsh[7:0]};
      default: rdata = 32'd0;
    endcase
  end

  assign DDT =
    (state == ACK && !wr_q && !WRITE) ?
    (fault_q ? 32'd0 : rdata) : 'z;

  assign ACKD_n  = !rst_n || (state != ACK && MREQ);
  assign bus_err = (state == ACK) && fault_q;

endmodule
